// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle control unit
package ctrl_pkg;
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;
    typedef enum logic [1:0] {SEL_HOLD, SEL_INC, SEL_BRANCH, SEL_JUMP} pc_sel_t;
    localparam logic [2:0] CLS_RALU   = 3'b000;
    localparam logic [2:0] CLS_IALU   = 3'b001;
    localparam logic [2:0] CLS_LOAD   = 3'b010;
    localparam logic [2:0] CLS_STORE  = 3'b011;
    localparam logic [2:0] CLS_BRANCH = 3'b100;
    localparam logic [2:0] CLS_JUMP   = 3'b101;
    localparam logic [5:0] OP_HALT    = 6'h3F;
    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_SIGN  = 1;
    localparam int FLAG_CARRY = 2;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC selection (hold, +1, branch, absolute jump)
module next_pc_calc
    import ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [15:0]       branch_offset,
    input  logic [25:0]       jump_target,
    input  pc_sel_t           select,
    output logic [ADDR_W-1:0] next_address
);
    // branch offset is signed and counted in instructions; jump target is zero-extended
    always_comb
        next_address = select == SEL_INC    ? pc_in + ADDR_W'(1) :
                       select == SEL_BRANCH ? pc_in + ADDR_W'($signed(branch_offset)) :
                       select == SEL_JUMP   ? ADDR_W'(jump_target) : pc_in;
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle instruction FSM driving datapath strobes and next PC (optional CTRL_ILLEGAL_TRAP_EN)
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int              ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode,
    input  logic [2:0]        flags,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [15:0]       branch_offset,
    input  logic [25:0]       jump_target,
    output logic              RegWrite,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              MemtoReg,
    output logic              DataPCSel,
    output logic              RegSelect,
    output logic [2:0]        ALUop,
    output logic [1:0]        ALUinSel,
    output logic [ADDR_W-1:0] next_address,
    output logic              pc_write,
    output logic              halted,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic              illegal,
`endif
    output logic [2:0]        state_o
);
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    state_t            state, nxt;
    pc_sel_t           sel;
    logic [5:0]        ir;
    logic [2:0]        flags_q, cls;
    logic              taken, undef, final_st, active;
    logic [ADDR_W-1:0] calc_addr;

    assign cls   = ir[5:3];
    assign undef = cls == 3'b110 || (cls == 3'b111 && ir != OP_HALT);
    assign taken = cls == CLS_BRANCH && (ir[1:0] == 2'd0 ? flags_q[FLAG_ZERO] :
                                         ir[1:0] == 2'd1 ? !flags_q[FLAG_ZERO] :
                                         ir[1:0] == 2'd2 ? flags_q[FLAG_SIGN] : flags_q[FLAG_CARRY]);

    // state, instruction and ALU-flag registers; ir is captured as FETCH ends so DECODE already sees it
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= FETCH;
            ir      <= '0;
            flags_q <= '0;
        end else begin
            state <= nxt;
            if (state == FETCH) ir <= opcode;
            if (state == EXEC && cls <= CLS_IALU) flags_q <= flags;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    // sticky illegal-opcode indication, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) illegal <= 1'b0;
        else if (state == EXEC && undef) illegal <= 1'b1;
    end
`endif

    // next-state: the path length depends on the opcode class
    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:  nxt = DECODE;
            DECODE: nxt = EXEC;
            EXEC:   nxt = ir == OP_HALT || (TRAP && undef)             ? HALT :
                          cls <= CLS_IALU || (cls == CLS_JUMP && ir[0]) ? WB :
                          cls == CLS_LOAD || cls == CLS_STORE          ? MEM : FETCH;
            MEM:    nxt = cls == CLS_LOAD ? WB : FETCH;
            WB:     nxt = FETCH;
            HALT:   nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    // strobes and next address; everything is forced idle while reset is low
    always_comb begin
        active       = reset && (state == DECODE || state == EXEC || state == MEM || state == WB);
        final_st     = state != FETCH && state != HALT && nxt == FETCH;
        sel          = !final_st ? SEL_HOLD : taken ? SEL_BRANCH : cls == CLS_JUMP ? SEL_JUMP : SEL_INC;
        pc_write     = reset && final_st;
        next_address = reset ? calc_addr : RESET_VECTOR;
        ALUop        = !active ? 3'b000 : cls <= CLS_IALU ? ir[2:0] : ALU_ADD;
        ALUinSel     = active && (cls == CLS_IALU || cls == CLS_LOAD || cls == CLS_STORE) ? 2'b01 : 2'b00;
        RegWrite     = reset && state == WB;
        MemRead      = reset && state == MEM && cls == CLS_LOAD;
        MemWrite     = reset && state == MEM && cls == CLS_STORE;
        MemtoReg     = reset && (state == MEM || state == WB) && cls == CLS_LOAD;
        DataPCSel    = reset && state == WB && cls == CLS_JUMP;
        RegSelect    = reset && state == WB && cls == CLS_JUMP;
        halted       = reset && state == HALT;
        state_o      = state;
    end

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc_in        (pc_in),
        .branch_offset(branch_offset),
        .jump_target  (jump_target),
        .select       (sel),
        .next_address (calc_addr)
    );
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench with a per-cycle reference model of the control unit
module tb_multicycle_control_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [2:0]  flags;
    logic [31:0] pc_in;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;
    logic        RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect, pc_write, halted;
    logic [2:0]  ALUop, state_o;
    logic [1:0]  ALUinSel;
    logic [31:0] next_address;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    typedef struct {
        logic [47:0] v;
        bit          cs;
        bit          il;
        string       nm;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] pc;
    logic [2:0]  fq;
    bit          ill;

    multicycle_control_unit #(.ADDR_W(32), .RESET_VECTOR(32'd0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .flags(flags), .pc_in(pc_in),
        .branch_offset(branch_offset), .jump_target(jump_target),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .DataPCSel(DataPCSel), .RegSelect(RegSelect), .ALUop(ALUop), .ALUinSel(ALUinSel),
        .next_address(next_address), .pc_write(pc_write), .halted(halted),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // monitor: every cycle with a pending expectation is compared at the falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [47:0] act;
            e   = q.pop_front();
            act = {state_o, RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect,
                   ALUop, ALUinSel, pc_write, halted, next_address};
            if (!e.cs) act[47:45] = e.v[47:45];
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.nm, act, e.v);
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            checks++;
            if (illegal !== e.il) begin
                errors++;
                $display("FAIL %s illegal: got %b want %b", e.nm, illegal, e.il);
            end
`endif
        end
    end

    task automatic push(input int st, input bit cs, input bit rw, input bit mr, input bit mw,
                        input bit mtr, input bit dps, input bit rsl, input logic [2:0] op,
                        input logic [1:0] ins, input bit pw, input bit h, input logic [31:0] na,
                        input string nm);
        exp_t e;
        e.v  = {3'(st), rw, mr, mw, mtr, dps, rsl, op, ins, pw, h, na};
        e.cs = cs;
        e.il = ill;
        e.nm = nm;
        q.push_back(e);
    endtask

    // two reset cycles; st is the state the DUT holds during the first one (-1 = unknown)
    task automatic reset_seq(input int st);
        reset = 1'b0;
        pc_in = $urandom;
        push(st, st >= 0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 32'd0, "reset1");
        @(posedge clk); #1;
        ill = 1'b0;
        pc_in = $urandom;
        push(0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 32'd0, "reset2");
        @(posedge clk); #1;
        reset = 1'b1;
        pc = 32'd0;
        fq = 3'd0;
    endtask

    // one instruction; abort_k >= 0 pulls reset low in that cycle of the instruction
    task automatic run(input logic [5:0] opc, input logic [15:0] off, input logic [25:0] tgt,
                       input logic [2:0] flg, input int abort_k, input string nm);
        int          path[$];
        int          cls, s;
        bit          last, taken, trap;
        logic [31:0] na;
        cls  = int'(opc[5:3]);
        trap = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        trap = cls >= 6 && opc != 6'h3F;
`endif
        path = {0, 1, 2};
        if (opc == 6'h3F || trap) path.push_back(5);
        else if (cls <= 1) path.push_back(4);
        else if (cls == 2) begin path.push_back(3); path.push_back(4); end
        else if (cls == 3) path.push_back(3);
        else if (cls == 5 && opc[0]) path.push_back(4);
        opcode = opc; branch_offset = off; jump_target = tgt; flags = flg;
        for (int k = 0; k < path.size(); k++) begin
            s = path[k];
            if (k == abort_k) begin
                reset_seq(s);
                return;
            end
            last  = k == path.size() - 1 && s != 5;
            taken = cls == 4 && (opc[1:0] == 2'd0 ? fq[0] : opc[1:0] == 2'd1 ? !fq[0] :
                                 opc[1:0] == 2'd2 ? fq[1] : fq[2]);
            na    = !last ? pc : taken ? pc + {{16{off[15]}}, off} : cls == 5 ? {6'b0, tgt} : pc + 32'd1;
            pc_in = pc;
            push(s, 1, s == 4, s == 3 && cls == 2, s == 3 && cls == 3, (s == 3 || s == 4) && cls == 2,
                 s == 4 && cls == 5, s == 4 && cls == 5,
                 (s >= 1 && s <= 4 && cls <= 1) ? opc[2:0] : 3'd0,
                 (s >= 1 && s <= 4 && cls >= 1 && cls <= 3) ? 2'b01 : 2'b00,
                 last, s == 5, na, nm);
            @(posedge clk); #1;
            if (s == 2 && cls <= 1) fq = flg;
            if (s == 2 && trap) ill = 1'b1;
            if (last) pc = na;
        end
        if (path[path.size()-1] == 5) begin
            for (int i = 0; i < 3; i++) begin
                pc_in = $urandom;
                push(5, 1, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 1, pc_in, "halt_hold");
                @(posedge clk); #1;
            end
            reset_seq(5);
        end
    endtask

    initial begin
        logic [5:0] opc;
        reset = 1'b0; opcode = '0; flags = '0; pc_in = '0; branch_offset = '0; jump_target = '0;
        pc = 32'd0; fq = 3'd0; ill = 1'b0;
        @(posedge clk); #1;
        reset_seq(-1);
        run(6'b000000, 16'd0, 26'd0, 3'b000, -1, "nop_after_reset");
        pc = 32'd5;
        run(6'b000010, 16'd0, 26'd0, 3'b110, -1, "ralu");
        run(6'b010000, 16'd0, 26'd0, 3'b000, -1, "load");
        run(6'b011000, 16'd0, 26'd0, 3'b111, -1, "store");
        run(6'b001000, 16'd0, 26'd0, 3'b001, -1, "ialu_z");
        pc = 32'd10;
        run(6'b100000, 16'hFFFC, 26'd0, 3'b000, -1, "bz_taken");
        run(6'b001000, 16'd0, 26'd0, 3'b000, -1, "ialu_nz");
        pc = 32'd10;
        run(6'b100000, 16'hFFFC, 26'd0, 3'b111, -1, "bz_not_taken");
        run(6'b101001, 16'd0, 26'h40, 3'b000, -1, "call");
        run(6'b101000, 16'd0, 26'h3FFFFFF, 3'b000, -1, "jump");
        run(6'b010000, 16'd0, 26'd0, 3'b000, 3, "load_abort");
        pc = 32'hFFFF_FFFF;
        run(6'b001011, 16'd0, 26'd0, 3'b100, -1, "wrap_inc");
        run(6'b100011, 16'hFFFF, 26'd0, 3'b000, -1, "bc_wrap_neg");
        run(6'b110000, 16'd0, 26'd0, 3'b000, -1, "undef_110000");
        pc = 32'd7;
        run(6'h3F, 16'd0, 26'd0, 3'b000, -1, "halt");
        for (int n = 0; n < 80; n++) begin
            opc = 6'($urandom);
            if (opc == 6'h3F && $urandom_range(0, 3) != 0) opc = 6'h01;
            if ($urandom_range(0, 5) == 0) pc = $urandom;
            run(opc, 16'($urandom), 26'($urandom), 3'($urandom),
                $urandom_range(0, 14) == 0 ? int'($urandom_range(0, 4)) : -1, "random");
        end
        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle control FSM directly upstream of arithmetic_and_memory_unit and program_counter_unit.
- Consumes opcode and flags from the datapath.
- Drives every datapath control strobe: RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect, ALUop, ALUinSel.
- Drives next_address into the PC unit, which loads it on every clk edge.

Parameters:
ADDR_W, 32, width of pc_in/next_address
RESET_VECTOR, 32'd0, next_address value during and immediately after reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
opcode  input  6  instruction opcode from datapath
flags  input  3  ALU flags: [0] zero, [1] sign, [2] carry
pc_in  input  ADDR_W  current PC from program_counter_unit
branch_offset  input  16  signed branch displacement, in instructions
jump_target  input  26  absolute jump target, zero-extended
RegWrite  output  1  register-file write strobe
MemRead  output  1  data-memory read strobe
MemWrite  output  1  data-memory write strobe
MemtoReg  output  1  write-back source: 1 = memory, 0 = ALU
DataPCSel  output  1  write-back data = PC+1 (link)
RegSelect  output  1  destination = link register
ALUop  output  3  ALU operation
ALUinSel  output  2  ALU operand B select: 00 = register, 01 = immediate
next_address  output  ADDR_W  PC value loaded on the next edge
pc_write  output  1  high in the final cycle of each instruction
halted  output  1  FSM in HALT state
state_o  output  3  current state, for debug

Behaviour:
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5.
- Reset (reset == 0 at an edge):
  - State becomes FETCH.
  - All strobes 0, ALUop = 0, ALUinSel = 0, pc_write = 0, halted = 0.
  - Latched opcode and flags_q cleared.
  - next_address = RESET_VECTOR while reset is low.
  - Reset mid-instruction aborts the instruction; no strobe is asserted on the reset edge.
- FETCH -> DECODE unconditionally.
- DECODE: latch opcode into ir. ALUop/ALUinSel derived from ir and held constant until the instruction retires.
- Opcode classes by ir[5:3]; path and latency:
  - 000 R-ALU: ALUop = ir[2:0], ALUinSel = 00. Path F-D-E-WB (4 cycles).
  - 001 I-ALU: ALUop = ir[2:0], ALUinSel = 01. Path F-D-E-WB (4 cycles).
  - 010 LOAD: ALUop = 000, ALUinSel = 01, MemtoReg = 1. Path F-D-E-M-WB (5 cycles).
  - 011 STORE: ALUop = 000, ALUinSel = 01. Path F-D-E-M (4 cycles).
  - 100 BRANCH: condition by ir[1:0]: 00 zero, 01 !zero, 10 sign, 11 carry, each tested on flags_q. Path F-D-E (3 cycles).
  - 101 JUMP: ir[0] = 1 selects CALL. JUMP path F-D-E; CALL path F-D-E-WB.
  - ir == 6'h3F: HALT.
  - Anything else: NOP, path F-D-E.
- flags_q captures flags at the end of EXEC for classes 000/001 only; all other classes leave it unchanged.
- Strobe timing:
  - RegWrite pulses exactly one cycle, in WB only.
  - MemRead (LOAD) and MemWrite (STORE) assert for exactly one cycle, in MEM only.
  - CALL in WB: RegWrite = 1, DataPCSel = 1, RegSelect = 1.
  - MemtoReg = 1 only in LOAD's MEM and WB states; 0 otherwise.
- next_address is combinational:
  - Non-final states: equals pc_in, so the PC holds.
  - Final state: pc_write = 1, and next_address is
    - taken branch: pc_in + sign_extend(branch_offset);
    - JUMP/CALL: {6'b0, jump_target};
    - otherwise: pc_in + 1.
- Arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- HALT:
  - Entered from EXEC; halted = 1, next_address = pc_in, all strobes 0.
  - HALT is left only by reset.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- When defined:
  - Undefined opcodes go from EXEC to HALT instead of executing as NOP.
  - An extra output, illegal (1 bit), is set and stays set until reset.
- When undefined: undefined opcodes execute as 3-cycle NOPs and the illegal port does not exist.

Decomposition:
- Shared package (ctrl_pkg):
  - state encodings;
  - opcode class constants (CLS_RALU, CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP);
  - OP_HALT = 6'h3F;
  - ALUop constants (ALU_ADD = 3'b000);
  - flag bit indices.
- One sub-module: next_pc_calc, purely combinational: inputs pc_in, branch_offset, jump_target, select; output next_address.

Test Plan:
1. reset = 0 for 2 edges, then 1 -> next_address = 0, all strobes 0, state_o = FETCH; PC stays 0 until the first pc_write.
2. R-ALU opcode 6'b000010 at pc_in = 5 -> ALUop = 010 and ALUinSel = 00 from DECODE; RegWrite high only in cycle 4; next_address = 6 with pc_write in cycle 4.
3. LOAD 6'b010000 -> MemRead high only in cycle 4; RegWrite and MemtoReg high in cycle 5; MemWrite never high. STORE 6'b011000 -> MemWrite high in cycle 4 only.
4. I-ALU producing flags = 3'b001, then BZ (6'b100000) at pc_in = 10 with branch_offset = -4 -> next_address = 6 in cycle 3. Same sequence with flags = 0 -> next_address = 11.
5. CALL 6'b101001 with jump_target = 26'h40 -> WB: RegWrite = DataPCSel = RegSelect = 1, next_address = 32'h40. Opcode 6'h3F -> halted = 1 and the PC frozen until reset.
6. reset driven low during LOAD's MEM state -> next edge: state FETCH, MemRead = 0, RegWrite never asserted. With CTRL_ILLEGAL_TRAP_EN, opcode 6'b110000 -> illegal = 1, halted = 1.
